// File: rtl/mips_lsu.sv
// MEM-stage load/store unit: byte/half/word lane steering, alignment exceptions,
// pipeline stall and a req / addr_ok / data_ok bus handshake with per-phase timeout.
module mips_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [2:0]            req_op,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  stall,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  exc_adel,
    output logic                  exc_ades,
    output logic                  bus_err,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [1:0]            bus_size,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic [1:0]            dbg_state
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_op;
    logic [OFF-1:0]     r_off;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic [31:0]        r_rdata;
    logic               r_bus_req;
    logic               r_bus_wr;
    logic [1:0]         r_bus_size;
    logic [ADDR_W-1:0]  r_bus_addr;
    logic [NB-1:0]      r_bus_wstrb;
    logic [DATA_W-1:0]  r_bus_wdata;

    logic               w_is_store;
    logic               w_misal;
    logic               w_accept;
    logic               w_tmo;
    logic               w_tmo_fire;
    logic [1:0]         w_size;
    logic [NB-1:0]      w_strb_base;
    logic [DATA_W-1:0]  w_wdata_rep;
    logic [31:0]        w_shift;
    logic [31:0]        w_load;

    assign w_is_store = req_op[2] & (req_op[1] | req_op[0]);

    always_comb begin
        w_size      = 2'd2;
        w_strb_base = NB'(15);
        w_wdata_rep = {(NB/4){req_wdata}};
        case (req_op)
            3'b000, 3'b001, 3'b101: begin
                w_size      = 2'd0;
                w_strb_base = NB'(1);
                w_wdata_rep = {NB{req_wdata[7:0]}};
            end
            3'b010, 3'b011, 3'b110: begin
                w_size      = 2'd1;
                w_strb_base = NB'(3);
                w_wdata_rep = {(NB/2){req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_misal  = ((w_size == 2'd1) && req_addr[0]) ||
                      ((w_size == 2'd2) && (req_addr[1:0] != 2'b00));
    assign w_accept = (r_state == S_IDLE) && req_valid && !w_misal;
    assign exc_adel = (r_state == S_IDLE) && req_valid && w_misal && !w_is_store;
    assign exc_ades = (r_state == S_IDLE) && req_valid && w_misal && w_is_store;

    // Load lane steering uses the latched byte offset, not the live request.
    assign w_shift = 32'(bus_rdata >> {r_off, 3'b000});

    always_comb begin
        w_load = w_shift;
        case (r_op)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {24'b0, w_shift[7:0]};
            3'b010:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b011:  w_load = {16'b0, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    // The counter value counts completed wait cycles; the cycle that would make
    // it reach TIMEOUT is the last one allowed in the phase.
    assign w_tmo      = (TIMEOUT > 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_tmo_fire = w_tmo && (((r_state == S_ADDR) && !bus_addr_ok) ||
                                  ((r_state == S_DATA) && !bus_data_ok));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_ADDR;
            S_ADDR: begin
                if (bus_addr_ok)     w_next = S_DATA;
                else if (w_tmo_fire) w_next = S_RESP;
            end
            S_DATA: begin
                if (bus_data_ok)     w_next = S_RESP;
                else if (w_tmo_fire) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_off       <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_bus_req   <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_size  <= '0;
            r_bus_addr  <= '0;
            r_bus_wstrb <= '0;
            r_bus_wdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op        <= req_op;
                        r_off       <= req_addr[OFF-1:0];
                        r_cnt       <= '0;
                        r_err       <= 1'b0;
                        r_bus_req   <= 1'b1;
                        r_bus_wr    <= w_is_store;
                        r_bus_size  <= w_size;
                        r_bus_addr  <= req_addr;
                        r_bus_wstrb <= w_is_store ? NB'(w_strb_base << req_addr[OFF-1:0]) : '0;
                        r_bus_wdata <= w_is_store ? w_wdata_rep : '0;
                    end
                end
                S_ADDR: begin
                    if (bus_addr_ok) begin
                        r_bus_req <= 1'b0;
                        r_cnt     <= '0;
                    end else if (w_tmo_fire) begin
                        r_bus_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_rdata   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bus_data_ok) begin
                        r_rdata <= w_load;
                    end else if (w_tmo_fire) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_err <= 1'b0;
            endcase
        end
    end

    assign stall     = w_accept || (r_state == S_ADDR) || (r_state == S_DATA);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign bus_err   = r_err;
    assign bus_req   = r_bus_req;
    assign bus_wr    = r_bus_wr;
    assign bus_size  = r_bus_size;
    assign bus_addr  = r_bus_addr;
    assign bus_wstrb = r_bus_wstrb;
    assign bus_wdata = r_bus_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mips_lsu.sv
// Bench for mips_lsu: a 32-bit and a 64-bit instance share the same stimulus and
// are checked against a byte-level reference model of loads, stores and timeouts.
module tb_mips_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [63:0] bus_rdata64;

    logic        a_stall, a_rspv, a_adel, a_ades, a_err, a_req, a_wr;
    logic [31:0] a_rd, a_addr, a_wdata;
    logic [1:0]  a_size, a_dbg;
    logic [3:0]  a_strb;
    logic        b_stall, b_rspv, b_adel, b_ades, b_err, b_req, b_wr;
    logic [31:0] b_rd, b_addr;
    logic [63:0] b_wdata;
    logic [1:0]  b_size, b_dbg;
    logic [7:0]  b_strb;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd[2];
    logic [7:0]  cap_strb[2];
    logic [63:0] cap_wdata[2];

    mips_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_dut32 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(a_stall), .rsp_valid(a_rspv), .rsp_rdata(a_rd),
        .exc_adel(a_adel), .exc_ades(a_ades), .bus_err(a_err), .bus_req(a_req), .bus_wr(a_wr),
        .bus_size(a_size), .bus_addr(a_addr), .bus_wstrb(a_strb), .bus_wdata(a_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata64[31:0]),
        .dbg_state(a_dbg)
    );

    mips_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) u_dut64 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(b_stall), .rsp_valid(b_rspv), .rsp_rdata(b_rd),
        .exc_adel(b_adel), .exc_ades(b_ades), .bus_err(b_err), .bus_req(b_req), .bus_wr(b_wr),
        .bus_size(b_size), .bus_addr(b_addr), .bus_wstrb(b_strb), .bus_wdata(b_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata64),
        .dbg_state(b_dbg)
    );

    // Unit 0 is the 32-bit instance, unit 1 the 64-bit one, widened for uniform checks.
    logic        stall_u[2], rspv_u[2], adel_u[2], ades_u[2], err_u[2], req_u[2], wr_u[2];
    logic [31:0] rd_u[2], addr_u[2];
    logic [1:0]  size_u[2], dbg_u[2];
    logic [7:0]  strb_u[2];
    logic [63:0] wdata_u[2];
    assign stall_u[0] = a_stall;  assign stall_u[1] = b_stall;
    assign rspv_u[0]  = a_rspv;   assign rspv_u[1]  = b_rspv;
    assign adel_u[0]  = a_adel;   assign adel_u[1]  = b_adel;
    assign ades_u[0]  = a_ades;   assign ades_u[1]  = b_ades;
    assign err_u[0]   = a_err;    assign err_u[1]   = b_err;
    assign req_u[0]   = a_req;    assign req_u[1]   = b_req;
    assign wr_u[0]    = a_wr;     assign wr_u[1]    = b_wr;
    assign rd_u[0]    = a_rd;     assign rd_u[1]    = b_rd;
    assign addr_u[0]  = a_addr;   assign addr_u[1]  = b_addr;
    assign size_u[0]  = a_size;   assign size_u[1]  = b_size;
    assign dbg_u[0]   = a_dbg;    assign dbg_u[1]   = b_dbg;
    assign strb_u[0]  = {4'b0, a_strb};   assign strb_u[1]  = b_strb;
    assign wdata_u[0] = {32'b0, a_wdata}; assign wdata_u[1] = b_wdata;

    always #5 clk = ~clk;

    function automatic int unit_dw(int u);
        return (u == 0) ? 32 : 64;
    endfunction

    function automatic int op_bytes(logic [2:0] op);
        if (op == 3'd0 || op == 3'd1 || op == 3'd5) return 1;
        if (op == 3'd2 || op == 3'd3 || op == 3'd6) return 2;
        return 4;
    endfunction

    function automatic logic is_store(logic [2:0] op);
        return op >= 3'd5;
    endfunction

    function automatic logic [1:0] m_size(logic [2:0] op);
        int n = op_bytes(op);
        return (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [7:0] m_strb(int dw, logic [2:0] op, logic [31:0] addr);
        int n = op_bytes(op);
        int o = int'(addr % 32'(dw / 8));
        if (!is_store(op)) return 8'h00;
        return 8'(((1 << n) - 1) << o);
    endfunction

    function automatic logic [63:0] m_wdata(int dw, logic [2:0] op, logic [31:0] wdata);
        logic [63:0] r = '0;
        int n = op_bytes(op);
        for (int i = 0; i < dw / 8; i++) r[8*i +: 8] = wdata[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(int dw, logic [2:0] op, logic [31:0] addr, logic [63:0] rdata);
        int n = op_bytes(op);
        int o = int'(addr % 32'(dw / 8));
        longint v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(rdata[8*(o+i) +: 8]) << (8*i));
        if ((op == 3'd0 || op == 3'd2) && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issues one aligned op in an IDLE cycle and walks it through ADDR, DATA and RESP.
    task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input int aw, input int dwt, input logic [63:0] rdata);
        logic [31:0] e;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        for (int u = 0; u < 2; u++) exp_q.push_back(m_load(unit_dw(u), op, addr, rdata));
        #1;
        for (int u = 0; u < 2; u++) begin
            n_vec++; if (stall_u[u] !== 1'b1) begin n_err++; $display("FAIL accept_stall u%0d got %b want 1", u, stall_u[u]); end
            n_vec++; if ((adel_u[u] | ades_u[u]) !== 1'b0) begin n_err++; $display("FAIL accept_exc u%0d got %b%b want 00", u, adel_u[u], ades_u[u]); end
        end
        tick();
        for (int k = 0; k <= aw; k++) begin
            for (int u = 0; u < 2; u++) begin
                if (k == 0) begin cap_strb[u] = strb_u[u]; cap_wdata[u] = wdata_u[u]; end
                n_vec++; if (req_u[u] !== 1'b1 || stall_u[u] !== 1'b1) begin n_err++; $display("FAIL addr_req u%0d got req=%b stall=%b want 1 1", u, req_u[u], stall_u[u]); end
                n_vec++; if (wr_u[u] !== is_store(op) || size_u[u] !== m_size(op) || addr_u[u] !== addr) begin
                    n_err++; $display("FAIL addr_fields u%0d got wr=%b size=%0d addr=%h want %b %0d %h", u, wr_u[u], size_u[u], addr_u[u], is_store(op), m_size(op), addr); end
                n_vec++; if (strb_u[u] !== m_strb(unit_dw(u), op, addr)) begin n_err++; $display("FAIL wstrb u%0d got %h want %h", u, strb_u[u], m_strb(unit_dw(u), op, addr)); end
                if (is_store(op)) begin
                    n_vec++; if (wdata_u[u] !== m_wdata(unit_dw(u), op, wdata)) begin n_err++; $display("FAIL wdata u%0d got %h want %h", u, wdata_u[u], m_wdata(unit_dw(u), op, wdata)); end
                end
            end
            bus_addr_ok = (k == aw);
            bus_data_ok = 1'($urandom_range(0, 1));
            bus_rdata64 = {$urandom, $urandom};
            tick();
        end
        bus_addr_ok = 1'b0;
        for (int k = 0; k <= dwt; k++) begin
            for (int u = 0; u < 2; u++) begin
                n_vec++; if (req_u[u] !== 1'b0 || stall_u[u] !== 1'b1 || rspv_u[u] !== 1'b0) begin
                    n_err++; $display("FAIL data_phase u%0d got req=%b stall=%b rsp=%b want 0 1 0", u, req_u[u], stall_u[u], rspv_u[u]); end
            end
            bus_data_ok = (k == dwt);
            bus_rdata64 = (k == dwt) ? rdata : {$urandom, $urandom};
            tick();
        end
        bus_data_ok = 1'b0;
        for (int u = 0; u < 2; u++) begin
            e = exp_q.pop_front();
            last_rd[u] = rd_u[u];
            n_vec++; if (rspv_u[u] !== 1'b1 || stall_u[u] !== 1'b0 || err_u[u] !== 1'b0) begin
                n_err++; $display("FAIL resp u%0d got rsp=%b stall=%b err=%b want 1 0 0", u, rspv_u[u], stall_u[u], err_u[u]); end
            if (!is_store(op)) begin
                n_vec++; if (rd_u[u] !== e) begin n_err++; $display("FAIL rdata u%0d op=%0d addr=%h got %h want %h", u, op, addr, rd_u[u], e); end
            end
        end
        tick();
        req_valid = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            n_vec++; if (rspv_u[u] !== 1'b0 || stall_u[u] !== 1'b0) begin n_err++; $display("FAIL post_idle u%0d got rsp=%b stall=%b want 0 0", u, rspv_u[u], stall_u[u]); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_vec++; if ({stall_u[u], rspv_u[u], err_u[u], req_u[u], wr_u[u]} !== 5'b0 || dbg_u[u] !== 2'd0) begin
                n_err++; $display("FAIL reset_ctrl u%0d got %b%b%b%b%b st=%0d want 00000 0", u, stall_u[u], rspv_u[u], err_u[u], req_u[u], wr_u[u], dbg_u[u]); end
            n_vec++; if (rd_u[u] !== 32'h0 || size_u[u] !== 2'd0 || addr_u[u] !== 32'h0 || strb_u[u] !== 8'h0 || wdata_u[u] !== 64'h0) begin
                n_err++; $display("FAIL reset_data u%0d got rd=%h size=%0d addr=%h strb=%h wd=%h want all 0", u, rd_u[u], size_u[u], addr_u[u], strb_u[u], wdata_u[u]); end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        do_op(3'd7, 32'h100, 32'hDEADBEEF, 0, 0, 64'h0);
        n_vec++; if (cap_strb[0] !== 8'h0F || cap_wdata[0] !== 64'hDEADBEEF) begin n_err++; $display("FAIL sw32 got %h %h want 0f deadbeef", cap_strb[0], cap_wdata[0]); end
        n_vec++; if (cap_strb[1] !== 8'h0F || cap_wdata[1] !== 64'hDEADBEEF_DEADBEEF) begin n_err++; $display("FAIL sw64 got %h %h want 0f deadbeefdeadbeef", cap_strb[1], cap_wdata[1]); end
        do_op(3'd0, 32'h103, 32'h0, 0, 0, 64'h00000000_80112233);
        n_vec++; if (last_rd[0] !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb32 got %h want ffffff80", last_rd[0]); end
        do_op(3'd1, 32'h103, 32'h0, 0, 0, 64'h00000000_80112233);
        n_vec++; if (last_rd[0] !== 32'h00000080) begin n_err++; $display("FAIL lbu32 got %h want 00000080", last_rd[0]); end
        do_op(3'd6, 32'h106, 32'h0000ABCD, 0, 0, 64'h0);
        n_vec++; if (cap_strb[1] !== 8'hC0 || cap_wdata[1] !== 64'hABCDABCD_ABCDABCD) begin n_err++; $display("FAIL sh64 got %h %h want c0 abcdabcdabcdabcd", cap_strb[1], cap_wdata[1]); end
        n_vec++; if (cap_strb[0] !== 8'h0C || cap_wdata[0] !== 64'hABCDABCD) begin n_err++; $display("FAIL sh32 got %h %h want 0c abcdabcd", cap_strb[0], cap_wdata[0]); end
        do_op(3'd3, 32'h106, 32'h0, 0, 0, 64'h12345678_9ABCDEF0);
        n_vec++; if (last_rd[1] !== 32'h00001234) begin n_err++; $display("FAIL lhu64 got %h want 00001234", last_rd[1]); end
        n_vec++; if (last_rd[0] !== 32'h00009ABC) begin n_err++; $display("FAIL lhu32 got %h want 00009abc", last_rd[0]); end
        do_op(3'd4, 32'h200, 32'h0, 3, 0, {$urandom, $urandom});
    endtask

    task automatic test_misaligned();
        logic [2:0]  ops[5] = '{3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        logic [2:0]  op;
        logic [31:0] addr;
        for (int t = 0; t < 12; t++) begin
            if (t == 0) begin op = 3'd4; addr = 32'h102; end
            else if (t == 1) begin op = 3'd6; addr = 32'h101; end
            else begin
                op = ops[$urandom_range(0, 4)];
                addr = $urandom;
                if (op_bytes(op) == 2) addr[0] = 1'b1;
                else addr[1:0] = 2'($urandom_range(1, 3));
            end
            req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = $urandom;
            #1;
            for (int u = 0; u < 2; u++) begin
                n_vec++; if (adel_u[u] !== !is_store(op) || ades_u[u] !== is_store(op) || stall_u[u] !== 1'b0) begin
                    n_err++; $display("FAIL misalign u%0d op=%0d addr=%h got adel=%b ades=%b stall=%b want %b %b 0", u, op, addr, adel_u[u], ades_u[u], stall_u[u], !is_store(op), is_store(op)); end
            end
            tick();
            req_valid = 1'b0;
            for (int u = 0; u < 2; u++) begin
                n_vec++; if (req_u[u] !== 1'b0 || stall_u[u] !== 1'b0) begin n_err++; $display("FAIL misalign_bus u%0d got req=%b stall=%b want 0 0", u, req_u[u], stall_u[u]); end
            end
        end
    endtask

    task automatic check_timeout_resp(input string name, input int n, input int want);
        n_vec++; if (n != want) begin n_err++; $display("FAIL %s_len got %0d want %0d", name, n, want); end
        for (int u = 0; u < 2; u++) begin
            n_vec++; if (rspv_u[u] !== 1'b1 || err_u[u] !== 1'b1 || rd_u[u] !== 32'h0 || req_u[u] !== 1'b0) begin
                n_err++; $display("FAIL %s_resp u%0d got rsp=%b err=%b rd=%h req=%b want 1 1 0 0", name, u, rspv_u[u], err_u[u], rd_u[u], req_u[u]); end
        end
        tick();
        req_valid = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            n_vec++; if (rspv_u[u] !== 1'b0 || err_u[u] !== 1'b0 || stall_u[u] !== 1'b0) begin
                n_err++; $display("FAIL %s_idle u%0d got rsp=%b err=%b stall=%b want 0 0 0", name, u, rspv_u[u], err_u[u], stall_u[u]); end
        end
    endtask

    task automatic test_timeout_addr();
        int n = 0;
        req_valid = 1'b1; req_op = 3'd4; req_addr = $urandom & 32'hFFFF_FFFC; req_wdata = 32'h0;
        tick();
        for (int k = 0; k < 12; k++) begin
            if (a_req !== 1'b1) break;
            n++;
            tick();
        end
        check_timeout_resp("tmo_addr", n, 4);
    endtask

    task automatic test_timeout_data();
        int n = 0;
        req_valid = 1'b1; req_op = 3'd2; req_addr = $urandom & 32'hFFFF_FFFE; req_wdata = 32'h0;
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (a_rspv === 1'b1) break;
            n++;
            tick();
        end
        check_timeout_resp("tmo_data", n, 4);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h300; req_wdata = 32'h0;
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        rst = 1'b1;
        req_valid = 1'b0;
        tick();
        rst = 1'b0;
        bus_data_ok = 1'b1;
        for (int u = 0; u < 2; u++) begin
            n_vec++; if (stall_u[u] !== 1'b0 || req_u[u] !== 1'b0 || rspv_u[u] !== 1'b0) begin
                n_err++; $display("FAIL rst_mid u%0d got stall=%b req=%b rsp=%b want 0 0 0", u, stall_u[u], req_u[u], rspv_u[u]); end
        end
        tick();
        bus_data_ok = 1'b0;
        for (int u = 0; u < 2; u++) begin
            n_vec++; if (rspv_u[u] !== 1'b0 || stall_u[u] !== 1'b0) begin n_err++; $display("FAIL rst_mid_after u%0d got rsp=%b stall=%b want 0 0", u, rspv_u[u], stall_u[u]); end
        end
        do_op(3'd4, 32'h304, 32'h0, 0, 1, {$urandom, $urandom});
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] addr;
        for (int t = 0; t < 40; t++) begin
            op   = 3'($urandom_range(0, 7));
            addr = $urandom;
            addr = addr & ~32'(op_bytes(op) - 1);
            do_op(op, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom});
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata64 = '0;
        test_reset();
        test_directed();
        test_misaligned();
        test_timeout_addr();
        test_timeout_data();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
